// File: rtl/opl3_timer_pkg.sv
// Shared constants and types for the OPL3 timer block: register addresses,
// control/status bit positions and the latched control word.
package opl3_timer_pkg;

    localparam logic [7:0] TIMER1_ADDR     = 8'h02;
    localparam logic [7:0] TIMER2_ADDR     = 8'h03;
    localparam logic [7:0] TIMER_CTRL_ADDR = 8'h04;

    // Bit positions within the 0x04 control byte
    localparam int RST_BIT   = 7;
    localparam int MASK1_BIT = 6;
    localparam int MASK2_BIT = 5;
    localparam int ST2_BIT   = 1;
    localparam int ST1_BIT   = 0;

    // Bit positions within the status byte
    localparam int IRQ_BIT = 7;
    localparam int FT1_BIT = 6;
    localparam int FT2_BIT = 5;

    typedef struct packed {
        logic mask1;
        logic mask2;
        logic st2;
        logic st1;
    } timer_ctrl_t;

endpackage

// File: rtl/opl3_timer_counter.sv
// 8-bit OPL3 timer up-counter: loads its preset on start, counts on tick while
// running, and reloads with a one-cycle ovf pulse when ticked at 0xFF.
module opl3_timer_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       run,
    input  logic       tick,
    input  logic [7:0] preset,
    output logic [7:0] count,
    output logic       ovf
);

    // A load swallows a coincident tick, so it also suppresses the overflow.
    assign ovf = run & tick & ~load & (count == 8'hFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'h00;
        end else if (load) begin
            count <= preset;
        end else if (run && tick) begin
            count <= ovf ? preset : count + 8'd1;
        end
    end

endmodule

// File: rtl/opl3_timer_ctrl.sv
// OPL3 timer controller: 80 us base tick, /T2_PRESCALE tick for Timer 2,
// host decode of registers 0x02..0x04, sticky overflow flags and IRQ.
module opl3_timer_ctrl
    import opl3_timer_pkg::*;
#(
    parameter int TICK_DIV_COUNT = 1146,
    parameter int T2_PRESCALE    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic [7:0] status,
    output logic       irq
);

    localparam int BW = (TICK_DIV_COUNT > 2) ? $clog2(TICK_DIV_COUNT) : 1;
    localparam int PW = (T2_PRESCALE > 1) ? $clog2(T2_PRESCALE) : 1;

    logic [BW-1:0] base_cnt;
    logic [PW-1:0] pre_cnt;
    logic          tick80;
    logic          tick320;

    assign tick80  = (base_cnt == BW'(TICK_DIV_COUNT - 1));
    assign tick320 = tick80 & (pre_cnt == PW'(T2_PRESCALE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_cnt <= '0;
            pre_cnt  <= '0;
        end else begin
            base_cnt <= tick80 ? '0 : base_cnt + 1'b1;
            if (tick80) begin
                pre_cnt <= tick320 ? '0 : pre_cnt + 1'b1;
            end
        end
    end

    logic        wr_t1;
    logic        wr_t2;
    logic        wr_ctrl;
    logic        clr_flags;
    logic        set_ctrl;
    logic [7:0]  preset1;
    logic [7:0]  preset2;
    logic [7:0]  preset1_eff;
    logic [7:0]  preset2_eff;
    timer_ctrl_t ctrl;
    logic        load1;
    logic        load2;
    logic        ovf1;
    logic        ovf2;
    logic [7:0]  count1;
    logic [7:0]  count2;
    logic        ft1;
    logic        ft2;

    assign wr_t1     = wr_en & (wr_addr == TIMER1_ADDR);
    assign wr_t2     = wr_en & (wr_addr == TIMER2_ADDR);
    assign wr_ctrl   = wr_en & (wr_addr == TIMER_CTRL_ADDR);
    assign clr_flags = wr_ctrl &  wr_data[RST_BIT];
    assign set_ctrl  = wr_ctrl & ~wr_data[RST_BIT];

    // A preset written on the overflow tick is the value the counter reloads.
    assign preset1_eff = wr_t1 ? wr_data : preset1;
    assign preset2_eff = wr_t2 ? wr_data : preset2;

    assign load1 = set_ctrl & wr_data[ST1_BIT] & ~ctrl.st1;
    assign load2 = set_ctrl & wr_data[ST2_BIT] & ~ctrl.st2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            preset1 <= 8'h00;
            preset2 <= 8'h00;
            ctrl    <= '0;
        end else begin
            preset1 <= preset1_eff;
            preset2 <= preset2_eff;
            if (set_ctrl) begin
                ctrl.mask1 <= wr_data[MASK1_BIT];
                ctrl.mask2 <= wr_data[MASK2_BIT];
                ctrl.st2   <= wr_data[ST2_BIT];
                ctrl.st1   <= wr_data[ST1_BIT];
            end
        end
    end

    opl3_timer_counter u_t1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load1),
        .run    (ctrl.st1),
        .tick   (tick80),
        .preset (preset1_eff),
        .count  (count1),
        .ovf    (ovf1)
    );

    opl3_timer_counter u_t2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load2),
        .run    (ctrl.st2),
        .tick   (tick320),
        .preset (preset2_eff),
        .count  (count2),
        .ovf    (ovf2)
    );

    // Set wins over clear so an overflow coincident with RST is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ft1 <= 1'b0;
            ft2 <= 1'b0;
        end else begin
            if (ovf1 && !ctrl.mask1) begin
                ft1 <= 1'b1;
            end else if (clr_flags) begin
                ft1 <= 1'b0;
            end
            if (ovf2 && !ctrl.mask2) begin
                ft2 <= 1'b1;
            end else if (clr_flags) begin
                ft2 <= 1'b0;
            end
        end
    end

    assign irq = ft1 | ft2;

    always_comb begin
        status          = 8'h00;
        status[IRQ_BIT] = irq;
        status[FT1_BIT] = ft1;
        status[FT2_BIT] = ft2;
    end

endmodule

// File: tb/tb_opl3_timer_ctrl.sv
// Self-checking bench for opl3_timer_ctrl: directed table, corner-case
// sequences and randomized writes against a cycle-indexed reference model.
module tb_opl3_timer_ctrl;

    localparam int TDC = 4;
    localparam int PS  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_addr = 8'h00;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] status;
    logic       irq;

    opl3_timer_ctrl #(.TICK_DIV_COUNT(TDC), .T2_PRESCALE(PS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .status  (status),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: k is the index of the next clock edge since reset release.
    int k;
    int pre1, pre2, cnt1, cnt2;
    bit m1, m2, s1, s2, f1, f2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, k);
        end
    endtask

    task automatic model_reset();
        k = 0; pre1 = 0; pre2 = 0; cnt1 = 0; cnt2 = 0;
        m1 = 0; m2 = 0; s1 = 0; s2 = 0; f1 = 0; f2 = 0;
    endtask

    function automatic int model_status();
        return ((f1 | f2) ? 32'h80 : 0) | (f1 ? 32'h40 : 0) | (f2 ? 32'h20 : 0);
    endfunction

    task automatic model_edge(input logic we, input logic [7:0] a, input logic [7:0] d);
        bit t1, t2, wc, clr, wr, o1, o2;
        int n1, n2;
        t1  = (k % TDC) == TDC - 1;
        t2  = (k % (TDC * PS)) == TDC * PS - 1;
        n1  = (we && a == 8'h02) ? int'(d) : pre1;
        n2  = (we && a == 8'h03) ? int'(d) : pre2;
        wc  = we && a == 8'h04;
        clr = wc && d[7];
        wr  = wc && !d[7];
        o1  = 0;
        o2  = 0;
        if (wr && d[0] && !s1) cnt1 = n1;
        else if (s1 && t1) begin
            if (cnt1 == 255) begin cnt1 = n1; o1 = 1; end
            else cnt1 = cnt1 + 1;
        end
        if (wr && d[1] && !s2) cnt2 = n2;
        else if (s2 && t2) begin
            if (cnt2 == 255) begin cnt2 = n2; o2 = 1; end
            else cnt2 = cnt2 + 1;
        end
        if (clr) begin f1 = 0; f2 = 0; end
        if (o1 && !m1) f1 = 1;
        if (o2 && !m2) f2 = 1;
        pre1 = n1;
        pre2 = n2;
        if (wr) begin m1 = d[6]; m2 = d[5]; s2 = d[1]; s1 = d[0]; end
        k++;
    endtask

    // One clock: drive inputs, step the model on the edge, compare 1 time unit later.
    task automatic cyc(input logic we, input logic [7:0] a, input logic [7:0] d);
        wr_en = we; wr_addr = a; wr_data = d;
        @(posedge clk);
        model_edge(we, a, d);
        #1;
        wr_en = 1'b0;
        check("status", status, model_status());
        check("irq", irq, f1 | f2);
        check("count1", dut.u_t1.count, cnt1);
        check("count2", dut.u_t2.count, cnt2);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 8'h00);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_status", status, 8'h00);
        check("rst_irq", irq, 1'b0);
        check("rst_count1", dut.u_t1.count, 8'h00);
        check("rst_count2", dut.u_t2.count, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Advance until the next edge is a Timer 1 overflow tick.
    task automatic wait_t1_ovf_edge();
        bit found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (s1 && cnt1 == 255 && (k % TDC) == TDC - 1) found = 1;
            else idle(1);
        end
        check("wait_t1_ovf", found, 1'b1);
    endtask

    task automatic wait_tick_edge();
        for (int i = 0; i < TDC && (k % TDC) != TDC - 1; i++) idle(1);
        check("wait_tick", (k % TDC) == TDC - 1, 1'b1);
    endtask

    typedef struct {
        logic       we;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[16];

    initial begin
        // Timer 1 basic from reset: preset 0xFE, ticks on edges 3,7,11,15...
        for (int i = 0; i < 16; i++) tbl[i] = '{1'b0, 8'h00, 8'h00, 8'h00};
        tbl[0]  = '{1'b1, 8'h02, 8'hFE, 8'h00};
        tbl[1]  = '{1'b1, 8'h04, 8'h01, 8'h00};
        tbl[7]  = '{1'b0, 8'h00, 8'h00, 8'hC0};
        tbl[8]  = '{1'b1, 8'h04, 8'h80, 8'h00};
        tbl[15] = '{1'b0, 8'h00, 8'h00, 8'hC0};

        model_reset();
        do_reset();

        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].we, tbl[i].a, tbl[i].d);
            check("tbl_status", status, tbl[i].exp);
        end

        // RST on the exact overflow edge: flag stays set.
        wait_t1_ovf_edge();
        cyc(1'b1, 8'h04, 8'h80);
        check("rst_vs_ovf", status, 8'hC0);

        // Start write coinciding with a tick loads the preset, tick dropped.
        cyc(1'b1, 8'h04, 8'h00);
        cyc(1'b1, 8'h02, 8'h10);
        wait_tick_edge();
        cyc(1'b1, 8'h04, 8'h01);
        check("start_vs_tick", dut.u_t1.count, 8'h10);

        // Stop at 0x80 and hold.
        cyc(1'b1, 8'h04, 8'h00);
        cyc(1'b1, 8'h02, 8'h80);
        wait_tick_edge();
        cyc(1'b1, 8'h04, 8'h01);
        cyc(1'b1, 8'h04, 8'h00);
        idle(100);
        check("stop_hold", dut.u_t1.count, 8'h80);

        // Restart reloads; rewriting ST1=1 while running does not.
        cyc(1'b1, 8'h02, 8'h33);
        cyc(1'b1, 8'h04, 8'h01);
        check("restart_load", dut.u_t1.count, 8'h33);
        idle(12);
        cyc(1'b1, 8'h04, 8'h01);
        check("rewrite_no_reload", dut.u_t1.count != 8'h33, 1'b1);

        // Timer 2 with T1 masked.
        cyc(1'b1, 8'h04, 8'h80);
        cyc(1'b1, 8'h04, 8'h00);
        cyc(1'b1, 8'h04, 8'h80);
        check("clear_all", status, 8'h00);
        cyc(1'b1, 8'h03, 8'hFF);
        cyc(1'b1, 8'h02, 8'hFF);
        cyc(1'b1, 8'h04, 8'h42);
        cyc(1'b1, 8'h04, 8'h43);
        idle(40);
        check("t2_masked_t1", status, 8'hA0);
        check("t2_irq", irq, 1'b1);

        // Asynchronous reset mid-count, between clock edges.
        #3;
        rst_n = 1'b0;
        #1;
        check("async_status", status, 8'h00);
        check("async_irq", irq, 1'b0);
        check("async_count1", dut.u_t1.count, 8'h00);
        check("async_count2", dut.u_t2.count, 8'h00);
        #1;
        rst_n = 1'b1;
        model_reset();

        // Idle after release: no flags, tick80 every TDC cycles.
        for (int i = 0; i < 2000; i++) begin
            cyc(1'b0, 8'h00, 8'h00);
            check("tick80", dut.tick80, (k % TDC) == TDC - 1);
        end

        // Randomized writes against the model.
        for (int i = 0; i < 3000; i++) begin
            logic       we;
            logic [7:0] a, d;
            int         r;
            we = ($urandom_range(0, 3) == 0);
            r  = $urandom_range(0, 4);
            a  = (r == 0) ? 8'h02 : (r == 1) ? 8'h03 : (r == 4) ? 8'($urandom) : 8'h04;
            if (a == 8'h02 || a == 8'h03) d = 8'($urandom_range(240, 255));
            else begin
                d = 8'($urandom);
                d[7] = ($urandom_range(0, 3) == 0);
            end
            cyc(we, a, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
